bsg_parallel_in_serial_out_full: RTL



---
 rtl/bsg_piso_pkg.sv | 16 +
 rtl/bsg_counter_clear_up.sv | 21 ++
 rtl/bsg_parallel_in_serial_out_full.sv | 91 +++++++++
 3 files changed

// File: rtl/bsg_piso_pkg.sv
// Shared state encoding and length helper for the full-vector parallel-in serial-out block.
// Also provides BSG_SAFE_CLOG2 when the surrounding codebase has not defined it.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

package bsg_piso_pkg;

    typedef enum logic [0:0] {e_piso_empty, e_piso_send} bsg_piso_state_e;

    // Requested lengths beyond the vector capacity are clamped to the capacity
    function automatic int bsg_piso_sat_len(input int len, input int max_els);
        return (len > max_els) ? max_els : len;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together yield init_val_p + 1.
module bsg_counter_clear_up #(
    parameter  int max_val_p    = 1,
    parameter  int init_val_p   = 0,
    localparam int ptr_width_lp = `BSG_SAFE_CLOG2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    output logic [ptr_width_lp-1:0] count_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            count_o <= ptr_width_lp'(init_val_p);
        else if (clear_i || up_i)
            count_o <= (clear_i ? ptr_width_lp'(init_val_p) : count_o) + ptr_width_lp'(up_i);
    end

endmodule

// File: rtl/bsg_parallel_in_serial_out_full.sv
// Accepts a whole els_p x width_p vector and emits len elements over a valid/yumi port.
// Define BSG_PISO_ZERO_BUBBLE_EN to accept the next vector on the cycle the last element leaves.
module bsg_parallel_in_serial_out_full
    import bsg_piso_pkg::*;
#(
    parameter  int width_p      = 8,
    parameter  int els_p        = 4,
    parameter  int hi_to_lo_p   = 0,
    localparam int lg_els_lp    = `BSG_SAFE_CLOG2(els_p),
    localparam int len_width_lp = `BSG_SAFE_CLOG2(els_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [len_width_lp-1:0]  len_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic                     last_o,
    input  logic                     yumi_i
);

    bsg_piso_state_e state_r, state_n;

    logic [els_p-1:0][width_p-1:0] data_r;
    logic [len_width_lp-1:0]       len_r, len_sat;
    logic [len_width_lp-1:0]       count_ext, last_idx;
    logic [lg_els_lp-1:0]          count_r, elem_idx;
    logic                          load, consume_last;

    assign len_sat   = len_width_lp'(bsg_piso_sat_len(int'(len_i), els_p));
    assign count_ext = len_width_lp'(count_r);
    assign last_idx  = len_r - len_width_lp'(1);

    assign v_o          = (state_r == e_piso_send);
    assign last_o       = v_o & (count_ext == last_idx);
    assign consume_last = yumi_i & last_o;
    assign load         = v_i & ready_o;

`ifdef BSG_PISO_ZERO_BUBBLE_EN
    assign ready_o = (state_r == e_piso_empty) | consume_last;
`else
    assign ready_o = (state_r == e_piso_empty);
`endif

    // Reverse order walks down from the last valid element, not from els_p-1
    assign elem_idx = (hi_to_lo_p != 0) ? lg_els_lp'(last_idx - count_ext) : count_r;
    assign data_o   = data_r[elem_idx];

    always_comb begin
        state_n = state_r;
        if (state_r == e_piso_empty) begin
            if (load && (len_sat != '0))
                state_n = e_piso_send;
        end else if (consume_last) begin
            state_n = (load && (len_sat != '0)) ? e_piso_send : e_piso_empty;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_piso_empty;
            len_r   <= '0;
        end else begin
            state_r <= state_n;
            if (load)
                len_r <= len_sat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load)
            data_r <= data_i;
    end

    // The count is already zero whenever a vector loads, so load needs no clear of its own
    bsg_counter_clear_up #(
        .max_val_p  (els_p - 1),
        .init_val_p (0)
    ) count_ctr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (consume_last),
        .up_i      (yumi_i & v_o & ~last_o),
        .count_o   (count_r)
    );

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule
